// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences 16/32-bit requests onto the 16-bit ripple ALU slice-array.
// Build option ALU_SEQ_SLT_EN turns op 111 into signed SLT32; otherwise op 111 returns rsp_err.
module alu_seq_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_ainvert,
    output logic        alu_bnegate,
    input  logic [15:0] alu_result,
    input  logic        alu_carry
);
    // state | meaning
    // IDLE  | waiting for a request, ALU inputs zero
    // LO    | low-half (or only) pass settling
    // HI    | high-half pass of a 32-bit op
    // FIX   | +/-1 correction of the high half
    // RESP  | response held until rsp_ready
    typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;

    localparam logic [2:0] OP_AND16 = 3'b000;
    localparam logic [2:0] OP_OR16  = 3'b001;
    localparam logic [2:0] OP_ADD16 = 3'b010;
    localparam logic [2:0] OP_SUB16 = 3'b011;
    localparam logic [2:0] OP_NOR16 = 3'b100;
    localparam logic [2:0] OP_ADD32 = 3'b101;
    localparam logic [2:0] OP_SUB32 = 3'b110;
    localparam logic [2:0] OP_SLT32 = 3'b111;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

`ifdef ALU_SEQ_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB16) || (op == OP_SUB32) || (op == OP_SLT32);
    endfunction

    function automatic logic is_wide(input logic [2:0] op);
        return (op == OP_ADD32) || (op == OP_SUB32) || (op == OP_SLT32);
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        return (op == OP_SLT32) && !SLT_EN;
    endfunction

    // {alu_op, ainvert, bnegate} for the first pass of each op
    function automatic logic [3:0] pass_enc(input logic [2:0] op);
        logic [3:0] enc;
        enc = 4'b0000;
        unique case (op)
            OP_AND16:                     enc = {ALU_AND, 1'b0, 1'b0};
            OP_OR16:                      enc = {ALU_OR,  1'b0, 1'b0};
            OP_ADD16, OP_ADD32:           enc = {ALU_ADD, 1'b0, 1'b0};
            OP_SUB16, OP_SUB32, OP_SLT32: enc = {ALU_ADD, 1'b0, 1'b1};
            OP_NOR16:                     enc = {ALU_AND, 1'b1, 1'b1};
            default:                      enc = 4'b0000;
        endcase
        return enc;
    endfunction

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  op_q, op_n;
    logic [15:0] ahi_q, ahi_n, bhi_q, bhi_n;
    logic [15:0] lo_q, lo_n;
    logic        clo_q, clo_n, c1_q, c1_n;
    logic [15:0] alu_a_n, alu_b_n;
    logic [1:0]  alu_op_n;
    logic        alu_ainvert_n, alu_bnegate_n;
    logic [31:0] rsp_result_n;
    logic        rsp_carry_n, rsp_zero_n, rsp_err_n;
    logic        do_finish;
    logic        c_fin, carry_fin;
    logic [31:0] res_fin;

    assign req_ready = (state == IDLE) && !reset;
    assign rsp_valid = (state == RESP);

    // Final 32-bit result and carry, valid on the capture edge of HI or FIX
    always_comb begin
        c_fin = alu_carry;
        if (state == FIX) begin
            c_fin = is_sub(op_q) ? (c1_q & alu_carry) : (c1_q | alu_carry);
        end
`ifdef ALU_SEQ_SLT_EN
        if (op_q == OP_SLT32) begin
            res_fin   = {31'b0, alu_result[15] ^ ((ahi_q[15] != bhi_q[15]) &
                                                  (alu_result[15] != ahi_q[15]))};
            carry_fin = 1'b0;
        end else begin
            res_fin   = {alu_result, lo_q};
            carry_fin = c_fin;
        end
`else
        res_fin   = {alu_result, lo_q};
        carry_fin = c_fin;
`endif
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        op_n          = op_q;
        ahi_n         = ahi_q;
        bhi_n         = bhi_q;
        lo_n          = lo_q;
        clo_n         = clo_q;
        c1_n          = c1_q;
        alu_a_n       = alu_a;
        alu_b_n       = alu_b;
        alu_op_n      = alu_op;
        alu_ainvert_n = alu_ainvert;
        alu_bnegate_n = alu_bnegate;
        rsp_result_n  = rsp_result;
        rsp_carry_n   = rsp_carry;
        rsp_zero_n    = rsp_zero;
        rsp_err_n     = rsp_err;
        do_finish     = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n    = req_op;
                    ahi_n   = req_a[31:16];
                    bhi_n   = req_b[31:16];
                    state_n = LO;
                    if (is_illegal(req_op)) begin
                        cnt_n = 4'd0;
                    end else begin
                        cnt_n   = SETTLE_M1;
                        alu_a_n = req_a[15:0];
                        alu_b_n = req_b[15:0];
                        {alu_op_n, alu_ainvert_n, alu_bnegate_n} = pass_enc(req_op);
                    end
                end
            end
            LO: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else if (is_illegal(op_q)) begin
                    rsp_result_n = 32'h0;
                    rsp_carry_n  = 1'b0;
                    rsp_zero_n   = 1'b0;
                    rsp_err_n    = 1'b1;
                    state_n      = RESP;
                end else if (!is_wide(op_q)) begin
                    rsp_result_n  = {16'h0, alu_result};
                    rsp_carry_n   = ((op_q == OP_ADD16) || (op_q == OP_SUB16)) & alu_carry;
                    rsp_zero_n    = (alu_result == 16'h0);
                    rsp_err_n     = 1'b0;
                    alu_a_n       = 16'h0;
                    alu_b_n       = 16'h0;
                    alu_op_n      = 2'b00;
                    alu_ainvert_n = 1'b0;
                    alu_bnegate_n = 1'b0;
                    state_n       = RESP;
                end else begin
                    lo_n          = alu_result;
                    clo_n         = alu_carry;
                    alu_a_n       = ahi_q;
                    alu_b_n       = bhi_q;
                    alu_op_n      = ALU_ADD;
                    alu_ainvert_n = 1'b0;
                    alu_bnegate_n = is_sub(op_q);
                    cnt_n         = SETTLE_M1;
                    state_n       = HI;
                end
            end
            HI: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    c1_n = alu_carry;
                    // Low half already produced the carry/borrow the high pass assumed
                    if (clo_q == is_sub(op_q)) begin
                        do_finish = 1'b1;
                    end else begin
                        alu_a_n       = alu_result;
                        alu_b_n       = 16'h0001;
                        alu_op_n      = ALU_ADD;
                        alu_ainvert_n = 1'b0;
                        alu_bnegate_n = is_sub(op_q);
                        cnt_n         = SETTLE_M1;
                        state_n       = FIX;
                    end
                end
            end
            FIX: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    do_finish = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_result_n = 32'h0;
                    rsp_carry_n  = 1'b0;
                    rsp_zero_n   = 1'b0;
                    rsp_err_n    = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (do_finish) begin
            rsp_result_n  = res_fin;
            rsp_carry_n   = carry_fin;
            rsp_zero_n    = (res_fin == 32'h0);
            rsp_err_n     = 1'b0;
            alu_a_n       = 16'h0;
            alu_b_n       = 16'h0;
            alu_op_n      = 2'b00;
            alu_ainvert_n = 1'b0;
            alu_bnegate_n = 1'b0;
            state_n       = RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 4'd0;
            op_q        <= 3'b000;
            ahi_q       <= 16'h0;
            bhi_q       <= 16'h0;
            lo_q        <= 16'h0;
            clo_q       <= 1'b0;
            c1_q        <= 1'b0;
            alu_a       <= 16'h0;
            alu_b       <= 16'h0;
            alu_op      <= 2'b00;
            alu_ainvert <= 1'b0;
            alu_bnegate <= 1'b0;
            rsp_result  <= 32'h0;
            rsp_carry   <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            op_q        <= op_n;
            ahi_q       <= ahi_n;
            bhi_q       <= bhi_n;
            lo_q        <= lo_n;
            clo_q       <= clo_n;
            c1_q        <= c1_n;
            alu_a       <= alu_a_n;
            alu_b       <= alu_b_n;
            alu_op      <= alu_op_n;
            alu_ainvert <= alu_ainvert_n;
            alu_bnegate <= alu_bnegate_n;
            rsp_result  <= rsp_result_n;
            rsp_carry   <= rsp_carry_n;
            rsp_zero    <= rsp_zero_n;
            rsp_err     <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 16-bit ALU, directed requests, queue-based response scoreboard.
module tb_alu_seq_ctrl;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_zero, rsp_err;
    logic [15:0] alu_a, alu_b;
    logic [1:0]  alu_op;
    logic        alu_ainvert, alu_bnegate;
    logic [15:0] alu_result;
    logic        alu_carry;

    alu_seq_ctrl #(.SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_ainvert(alu_ainvert), .alu_bnegate(alu_bnegate),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    // Combinational ripple ALU: bnegate inverts B and forces carry-in
    logic [15:0] aa, bb;
    logic [16:0] sum;
    always_comb begin
        aa  = alu_ainvert ? ~alu_a : alu_a;
        bb  = alu_bnegate ? ~alu_b : alu_b;
        sum = {1'b0, aa} + {1'b0, bb} + {16'h0, alu_bnegate};
        case (alu_op)
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            default: alu_result = sum[15:0];
        endcase
        alu_carry = sum[16];
    end

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        e;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Monitor: compare each response on the cycle it is handed over
    always @(negedge clk) begin
        #2;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result 0x%08h, expected no response", rsp_result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_flags", {29'b0, rsp_carry, rsp_zero, rsp_err},
                    {29'b0, mon_e.c, mon_e.z, mon_e.e});
            end
        end
    end

    task automatic send(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eres, input logic ec,
                        input logic ez, input logic ee, input int passes,
                        input bit fix, input logic fbneg, input int stall);
        int          n;
        int          elat;
        logic [15:0] last_b;
        logic        last_bneg;
        logic [34:0] held;
        elat = (passes == 0) ? 1 : passes * SETTLE;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: req_ready 0, expected 1", name);
            return;
        end
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        sb_q.push_back('{res: eres, c: ec, z: ez, e: ee});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_a     = ~a;
        req_b     = 32'h5A5A_A5A5;
        n         = 0;
        last_b    = 16'h0;
        last_bneg = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
            last_b    = alu_b;
            last_bneg = alu_bnegate;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout: rsp_valid 0 after %0d cycles, expected 1", name, n);
            void'(sb_q.pop_back());
            rsp_ready = 1'b1;
            return;
        end
        chk({name, "_latency"}, 32'(n - 1), 32'(elat));
        if (fix) begin
            chk({name, "_fix_b"}, {16'h0, last_b}, 32'h0000_0001);
            chk({name, "_fix_bneg"}, {31'b0, last_bneg}, {31'b0, fbneg});
        end
        if (stall > 0) begin
            held = {rsp_result, rsp_carry, rsp_zero, rsp_err};
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk({name, "_stall_hold"}, held[34:3], rsp_result);
                chk({name, "_stall_ctl"}, {29'b0, rsp_valid, req_ready, rsp_err},
                    {29'b0, 1'b1, 1'b0, held[0]});
            end
            #1;
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        chk({name, "_post_hs"}, {30'b0, req_ready, rsp_valid}, {30'b0, 1'b1, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_alu", {alu_a, alu_b}, 32'h0);
        chk("reset_ctl", {24'b0, alu_op, alu_ainvert, alu_bnegate, rsp_valid, rsp_carry, rsp_zero, rsp_err}, 32'h0);
        chk("reset_result", rsp_result, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, req_ready}, 32'h1);

        //    name         op      a             b             result        c     z     e    passes fix  bneg stall
        send("add16",     3'b010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 0);
        send("sub16_eq",  3'b011, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 0);
        send("nor16",     3'b100, 32'h0000_00F0, 32'h0000_000F, 32'h0000_FF00, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 0);
        send("and16",     3'b000, 32'hABCD_0FF0, 32'h1234_00FF, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 0);
        send("or16",      3'b001, 32'hFFFF_1200, 32'hFFFF_0034, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 0);
        send("add16_wrap",3'b010, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 0);
        send("add32_fix", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 3, 1, 1'b0, 0);
        send("sub32_fix", 3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 3, 1, 1'b1, 0);
        send("sub32_nofix",3'b110,32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 0);
        send("add32_mid", 3'b101, 32'h0001_8000, 32'h0002_8000, 32'h0004_0000, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 0);
        send("add32_hic", 3'b101, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0, 0);
        send("sub16_stall",3'b011,32'h0000_0010, 32'h0000_0020, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 5);
`ifdef ALU_SEQ_SLT_EN
        send("slt_lt",    3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 3, 1, 1'b1, 0);
        send("slt_ge",    3'b111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0, 0);
`else
        send("illegal",   3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 0);
`endif

        // Reset in the middle of an ADD32 high-half pass
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b101;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'h0000_0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (SETTLE + 1) @(negedge clk);
        chk("hi_pass_a", {16'h0, alu_a}, 32'h0000_FFFF);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_alu", {alu_a, alu_b}, 32'h0);
        chk("midreset_ctl", {24'b0, alu_op, alu_ainvert, alu_bnegate, rsp_valid, rsp_carry, rsp_zero, rsp_err}, 32'h0);
        chk("midreset_result", rsp_result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        send("after_reset",3'b010,32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
